l2_input_arbiter: RTL and testbench

L2_INPUT_ARBITER -- requirements
Module: l2_input_arbiter

---
 rtl/l2_input_arbiter.sv | 173 +++++++++++++++++
 tb/tb_l2_input_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_input_arbiter.sv
// ---------------------------------------------------------------------------
// l2_input_arbiter
//
// Picks one of N_CH request channels into the L2 pipeline each cycle that
// decode_en is high. Channel 0 has the highest static priority. A per-channel
// age counter stops low-priority channels from starving: a channel that keeps
// losing while eligible becomes urgent after STARVE_MAX lost cycles. Urgent
// channels beat all non-urgent ones. STARVE_MAX = 0 turns the arbiter into a
// plain fixed-priority arbiter.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-low reset (clears grant regs and ages)
//   decode_en      arbitration / register-update enable
//   valid[N_CH]    new request per channel
//   replay[N_CH]   stalled request waiting to be replayed per channel
//   block[N_CH]    per-channel inhibit
//   line_addr      packed line addresses, channel i at [i*LINE_W +: LINE_W]
//   ready          combinational accept of a new request
//   replay_ack     combinational accept of a replayed request
//   grant_oh_next  combinational one-hot winner
//   urgent_any     combinational: some channel is urgent
//   grant_vld      registered: a winner was selected
//   grant_oh       registered one-hot winner
//   grant_idx      registered winner index
//   grant_tag      registered winner tag  (line_addr[LINE_W-1:SET_BITS])
//   grant_set      registered winner set  (line_addr[SET_BITS-1:0])
// ---------------------------------------------------------------------------
module l2_input_arbiter #(
    parameter int N_CH       = 4,
    parameter int LINE_W     = 26,
    parameter int SET_BITS   = 8,
    parameter int STARVE_MAX = 7,
    localparam int IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AGE_W     = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1,
    localparam int TAG_W     = LINE_W - SET_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     decode_en,
    input  logic [N_CH-1:0]          valid,
    input  logic [N_CH-1:0]          replay,
    input  logic [N_CH-1:0]          block,
    input  logic [N_CH*LINE_W-1:0]   line_addr,
    output logic [N_CH-1:0]          ready,
    output logic [N_CH-1:0]          replay_ack,
    output logic [N_CH-1:0]          grant_oh_next,
    output logic                     urgent_any,
    output logic                     grant_vld,
    output logic [N_CH-1:0]          grant_oh,
    output logic [IDX_W-1:0]         grant_idx,
    output logic [TAG_W-1:0]         grant_tag,
    output logic [SET_BITS-1:0]      grant_set
);

    localparam logic             AGING_EN = (STARVE_MAX != 0);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_MAX);

    logic [N_CH-1:0]     elig;
    logic [N_CH-1:0]     urgent;
    logic                win_vld;
    logic [IDX_W-1:0]    win_idx;
    logic [LINE_W-1:0]   win_addr;

    logic [AGE_W-1:0]    age_q [N_CH];
    logic [AGE_W-1:0]    age_d [N_CH];

    logic                grant_vld_q, grant_vld_d;
    logic [N_CH-1:0]     grant_oh_q,  grant_oh_d;
    logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
    logic [TAG_W-1:0]    grant_tag_q, grant_tag_d;
    logic [SET_BITS-1:0] grant_set_q, grant_set_d;

    // Stage 0: eligibility, urgency and winner selection (combinational)
    always_comb begin
        elig    = '0;
        urgent  = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            elig[i]   = decode_en & (valid[i] | replay[i]) & ~block[i];
            urgent[i] = elig[i] & AGING_EN & (age_q[i] == AGE_MAX);
        end
        // Scan from the top down so the lowest index is the last to land;
        // the urgent scan runs second so any urgent channel overrides.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (urgent[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        grant_oh_next = '0;
        win_addr      = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant_oh_next[i] = win_vld & (win_idx == IDX_W'(i));
            if (grant_oh_next[i]) begin
                win_addr = line_addr[i*LINE_W +: LINE_W];
            end
        end
    end

    // A replay on the winning channel is served ahead of a new request.
    assign ready      = grant_oh_next & ~replay;
    assign replay_ack = grant_oh_next & replay;
    assign urgent_any = |urgent;

    // Next-state for grant registers and age counters; everything holds
    // while decode_en is low.
    always_comb begin
        grant_vld_d = grant_vld_q;
        grant_oh_d  = grant_oh_q;
        grant_idx_d = grant_idx_q;
        grant_tag_d = grant_tag_q;
        grant_set_d = grant_set_q;
        for (int i = 0; i < N_CH; i++) begin
            age_d[i] = age_q[i];
        end
        if (decode_en) begin
            // win_idx and win_addr are zero when nothing wins, which makes
            // the no-winner case load all zeros.
            grant_vld_d = win_vld;
            grant_oh_d  = grant_oh_next;
            grant_idx_d = win_idx;
            grant_tag_d = win_addr[LINE_W-1:SET_BITS];
            grant_set_d = win_addr[SET_BITS-1:0];
            for (int i = 0; i < N_CH; i++) begin
                if (!AGING_EN || grant_oh_next[i] || !elig[i]) begin
                    age_d[i] = '0;
                end else if (age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    // Stage 1: grant registers and age counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_vld_q <= 1'b0;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            grant_tag_q <= '0;
            grant_set_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            grant_vld_q <= grant_vld_d;
            grant_oh_q  <= grant_oh_d;
            grant_idx_q <= grant_idx_d;
            grant_tag_q <= grant_tag_d;
            grant_set_q <= grant_set_d;
            for (int i = 0; i < N_CH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign grant_vld = grant_vld_q;
    assign grant_oh  = grant_oh_q;
    assign grant_idx = grant_idx_q;
    assign grant_tag = grant_tag_q;
    assign grant_set = grant_set_q;

endmodule

// File: tb/tb_l2_input_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_input_arbiter
//
// Directed bench for l2_input_arbiter with N_CH=4, LINE_W=26, SET_BITS=8,
// STARVE_MAX=3. Inputs change 1 time unit after a rising edge; outputs are
// sampled 1-4 time units after an edge, well clear of the next one.
// ---------------------------------------------------------------------------
module tb_l2_input_arbiter;

    localparam int N_CH       = 4;
    localparam int LINE_W     = 26;
    localparam int SET_BITS   = 8;
    localparam int STARVE_MAX = 3;

    logic                   clk;
    logic                   rst_n;
    logic                   decode_en;
    logic [N_CH-1:0]        valid;
    logic [N_CH-1:0]        replay;
    logic [N_CH-1:0]        block;
    logic [N_CH*LINE_W-1:0] line_addr;
    logic [N_CH-1:0]        ready;
    logic [N_CH-1:0]        replay_ack;
    logic [N_CH-1:0]        grant_oh_next;
    logic                   urgent_any;
    logic                   grant_vld;
    logic [N_CH-1:0]        grant_oh;
    logic [1:0]             grant_idx;
    logic [17:0]            grant_tag;
    logic [7:0]             grant_set;

    int checks;
    int errors;

    l2_input_arbiter #(
        .N_CH       (N_CH),
        .LINE_W     (LINE_W),
        .SET_BITS   (SET_BITS),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst_n),
        .decode_en     (decode_en),
        .valid         (valid),
        .replay        (replay),
        .block         (block),
        .line_addr     (line_addr),
        .ready         (ready),
        .replay_ack    (replay_ack),
        .grant_oh_next (grant_oh_next),
        .urgent_any    (urgent_any),
        .grant_vld     (grant_vld),
        .grant_oh      (grant_oh),
        .grant_idx     (grant_idx),
        .grant_tag     (grant_tag),
        .grant_set     (grant_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int ch, input logic [LINE_W-1:0] a);
        line_addr[ch*LINE_W +: LINE_W] = a;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        decode_en = 1'b0;
        valid     = '0;
        replay    = '0;
        block     = '0;
        line_addr = '0;

        // Reset state
        #12;
        chk("rst_grant_vld", 32'(grant_vld), 32'h0);
        chk("rst_grant_oh",  32'(grant_oh),  32'h0);
        chk("rst_grant_idx", 32'(grant_idx), 32'h0);
        chk("rst_grant_tag", 32'(grant_tag), 32'h0);
        chk("rst_grant_set", 32'(grant_set), 32'h0);
        chk("rst_age3",      32'(dut.age_q[3]), 32'h0);
        rst_n = 1'b1;

        // Static priority
        tick();
        decode_en = 1'b1;
        valid     = 4'b0101;
        set_addr(0, 26'h0ABCD12);
        set_addr(2, 26'h1234567);
        #1;
        chk("prio_ready",      32'(ready),         32'h1);
        chk("prio_replay_ack", 32'(replay_ack),    32'h0);
        chk("prio_oh_next",    32'(grant_oh_next), 32'h1);
        tick();
        chk("prio_grant_vld", 32'(grant_vld), 32'h1);
        chk("prio_grant_idx", 32'(grant_idx), 32'h0);
        chk("prio_grant_tag", 32'(grant_tag), 32'h0ABCD);
        chk("prio_grant_set", 32'(grant_set), 32'h12);
        chk("prio_age2",      32'(dut.age_q[2]), 32'h1);
        valid = 4'b0000;
        tick();
        chk("idle_grant_vld", 32'(grant_vld), 32'h0);
        chk("idle_age2",      32'(dut.age_q[2]), 32'h0);

        // Anti-starvation
        set_addr(3, 26'h3FFFFFF);
        valid = 4'b1001;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk("starve_oh_next_ch0", 32'(grant_oh_next), 32'h1);
            tick();
            chk("starve_idx_ch0", 32'(grant_idx), 32'h0);
            chk("starve_age3",    32'(dut.age_q[3]), 32'(c));
        end
        #1;
        chk("starve_urgent_any", 32'(urgent_any),    32'h1);
        chk("starve_oh_next_u",  32'(grant_oh_next), 32'h8);
        chk("starve_ready_u",    32'(ready),         32'h8);
        tick();
        chk("starve_idx_ch3", 32'(grant_idx), 32'h3);
        chk("starve_tag_ch3", 32'(grant_tag), 32'h3FFFF);
        chk("starve_set_ch3", 32'(grant_set), 32'hFF);
        chk("starve_age3_clr", 32'(dut.age_q[3]), 32'h0);
        chk("starve_age0_inc", 32'(dut.age_q[0]), 32'h1);
        #1;
        chk("starve_oh_next_back", 32'(grant_oh_next), 32'h1);
        tick();
        chk("starve_idx_back",  32'(grant_idx), 32'h0);
        chk("starve_age3_back", 32'(dut.age_q[3]), 32'h1);
        chk("starve_age0_back", 32'(dut.age_q[0]), 32'h0);
        valid = 4'b0000;
        tick();

        // Replay
        set_addr(1, 26'h2AAAA55);
        valid  = 4'b0010;
        replay = 4'b0010;
        #1;
        chk("replay_ack",   32'(replay_ack), 32'h2);
        chk("replay_ready", 32'(ready),      32'h0);
        tick();
        chk("replay_idx",     32'(grant_idx), 32'h1);
        chk("replay_oh",      32'(grant_oh),  32'h2);
        chk("replay_tag",     32'(grant_tag), 32'h2AAAA);
        chk("replay_set",     32'(grant_set), 32'h55);
        valid  = 4'b0100;
        block  = 4'b0010;
        #1;
        chk("replay_blk_ready", 32'(ready),      32'h4);
        chk("replay_blk_ack",   32'(replay_ack), 32'h0);
        tick();
        chk("replay_blk_idx", 32'(grant_idx), 32'h2);

        // Block
        replay = 4'b0000;
        valid  = 4'b0011;
        block  = 4'b0001;
        #1;
        chk("block_ready", 32'(ready), 32'h2);
        tick();
        chk("block_idx",  32'(grant_idx), 32'h1);
        chk("block_age0", 32'(dut.age_q[0]), 32'h0);
        valid = 4'b0000;
        block = 4'b0000;
        tick();
        chk("nowin_grant_vld", 32'(grant_vld), 32'h0);
        chk("nowin_grant_idx", 32'(grant_idx), 32'h0);
        chk("nowin_grant_oh",  32'(grant_oh),  32'h0);
        chk("nowin_grant_tag", 32'(grant_tag), 32'h0);

        // Blocking an urgent channel
        valid = 4'b1001;
        tick();
        tick();
        tick();
        chk("blk_urg_age3_sat", 32'(dut.age_q[3]), 32'h3);
        block = 4'b1000;
        #1;
        chk("blk_urg_urgent_any", 32'(urgent_any), 32'h0);
        chk("blk_urg_ready",      32'(ready),      32'h1);
        tick();
        chk("blk_urg_age3_clr", 32'(dut.age_q[3]), 32'h0);
        block = 4'b0000;
        tick();
        chk("pre_hold_age3", 32'(dut.age_q[3]), 32'h1);

        // Enable low
        decode_en = 1'b0;
        valid     = 4'b1111;
        #1;
        chk("en_lo_ready",      32'(ready),         32'h0);
        chk("en_lo_replay_ack", 32'(replay_ack),    32'h0);
        chk("en_lo_oh_next",    32'(grant_oh_next), 32'h0);
        chk("en_lo_urgent_any", 32'(urgent_any),    32'h0);
        tick();
        tick();
        chk("en_lo_grant_vld", 32'(grant_vld), 32'h1);
        chk("en_lo_grant_idx", 32'(grant_idx), 32'h0);
        chk("en_lo_grant_oh",  32'(grant_oh),  32'h1);
        chk("en_lo_age3",      32'(dut.age_q[3]), 32'h1);

        // Reset mid-operation
        decode_en = 1'b1;
        valid     = 4'b1001;
        tick();
        chk("mid_age3",      32'(dut.age_q[3]), 32'h2);
        chk("mid_grant_vld", 32'(grant_vld), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_grant_vld", 32'(grant_vld), 32'h0);
        chk("arst_grant_oh",  32'(grant_oh),  32'h0);
        chk("arst_grant_idx", 32'(grant_idx), 32'h0);
        chk("arst_grant_tag", 32'(grant_tag), 32'h0);
        chk("arst_grant_set", 32'(grant_set), 32'h0);
        chk("arst_age3",      32'(dut.age_q[3]), 32'h0);
        chk("arst_oh_next",   32'(grant_oh_next), 32'h1);
        chk("arst_urgent",    32'(urgent_any),    32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_grant_vld", 32'(grant_vld), 32'h1);
        chk("post_rst_grant_idx", 32'(grant_idx), 32'h0);
        chk("post_rst_age3",      32'(dut.age_q[3]), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
